max_min_4_sort_ctrl: RTL and testbench

- Iterative 4-element bitonic sorter that time-multiplexes one pair of compare-exchange units over three network steps.
- An FSM sequences the steps; valid/ready handshakes sit on input and output.
- Sits upstream of the vcrc sorting datapath. It trades throughput for area against the fully pipelined 4-lane compare stages.

---
 rtl/max_min_4_sort_ctrl.sv | 111 +++++++++++
 tb/tb_max_min_4_sort_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/max_min_4_sort_ctrl.sv
// rtl/max_min_4_sort_ctrl.sv - iterative 4-element bitonic sorter sharing two compare-exchange units
module max_min_4_sort_ctrl #(
   parameter int width = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [width-1:0] in_data [0:3],
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out_data [0:3],
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      STEP1 = 3'd1,
      STEP2 = 3'd2,
      STEP3 = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [width-1:0] w_q [0:3];
   logic [width-1:0] w_d [0:3];
   logic             dir_q, dir_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc;

   // Compare-exchange: returns {first, second}; first gets the larger value when first_max is set.
   // Equal operands come back unchanged, so ties never swap.
   function automatic logic [2*width-1:0] cx(input logic [width-1:0] a,
                                            input logic [width-1:0] b,
                                            input logic             first_max);
      logic [width-1:0] hi;
      logic [width-1:0] lo;
      hi = (a >= b) ? a : b;
      lo = (a >= b) ? b : a;
      return first_max ? {hi, lo} : {lo, hi};
   endfunction

   // Handshake and status outputs; reset forces both handshakes low.
   always_comb begin
      in_ready  = rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
      out_valid = rst && (state_q == DONE);
      busy      = (state_q == STEP1) || (state_q == STEP2) || (state_q == STEP3);
      acc       = in_valid && in_ready;
   end

   assign out_data = w_q;
   assign blk_cnt  = cnt_q;

   // Next-state: one network step per clock; a new block may be loaded from IDLE or on the DONE handoff.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: ;
         STEP1: begin
            // First half sorted toward dir, second half against it, forming a bitonic sequence.
            {w_d[0], w_d[1]} = cx(w_q[0], w_q[1], !dir_q);
            {w_d[2], w_d[3]} = cx(w_q[2], w_q[3],  dir_q);
            state_d = STEP2;
         end
         STEP2: begin
            {w_d[0], w_d[2]} = cx(w_q[0], w_q[2], !dir_q);
            {w_d[1], w_d[3]} = cx(w_q[1], w_q[3], !dir_q);
            state_d = STEP3;
         end
         STEP3: begin
            {w_d[0], w_d[1]} = cx(w_q[0], w_q[1], !dir_q);
            {w_d[2], w_d[3]} = cx(w_q[2], w_q[3], !dir_q);
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (acc) begin
         w_d     = in_data;
         dir_d   = in_dir;
         state_d = STEP1;
      end
   end

   // State, work registers, direction and block counter; async reset discards any in-flight block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         for (int i = 0; i < 4; i++) w_q[i] <= '0;
         dir_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_max_min_4_sort_ctrl.sv
// tb/tb_max_min_4_sort_ctrl.sv - self-checking bench for max_min_4_sort_ctrl
module tb_max_min_4_sort_ctrl;

   localparam int W     = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data [0:3];
   logic             in_dir;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_data [0:3];
   logic             busy;
   logic [CNT_W-1:0] blk_cnt;

   int checks = 0;
   int errors = 0;
   int model_cnt = 0;

   typedef struct packed {
      logic [31:0] din;
      logic        dir;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [0:3];

   max_min_4_sort_ctrl #(.width(W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_dir   (in_dir),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy),
      .blk_cnt  (blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack_out();
      return {out_data[0], out_data[1], out_data[2], out_data[3]};
   endfunction

   // Reference: plain selection sort to ascending, reversed for descending.
   function automatic logic [31:0] ref_sort(input logic [31:0] din, input logic dir);
      int a [4];
      int t;
      logic [31:0] r;
      for (int i = 0; i < 4; i++) a[i] = int'(din[31-8*i -: 8]);
      for (int i = 0; i < 3; i++)
         for (int j = i + 1; j < 4; j++)
            if (a[j] < a[i]) begin t = a[i]; a[i] = a[j]; a[j] = t; end
      r = '0;
      for (int i = 0; i < 4; i++) begin
         t = dir ? a[i] : a[3-i];
         r[31-8*i -: 8] = 8'(t);
      end
      return r;
   endfunction

   task automatic drive_block(input logic [31:0] din, input logic dir);
      for (int i = 0; i < 4; i++) in_data[i] = din[31-8*i -: 8];
      in_dir   = dir;
      in_valid = 1'b1;
   endtask

   task automatic scramble();
      for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
      in_dir = 1'($urandom);
   endtask

   // Called at a negedge just after the accept edge; returns clocks until out_valid (bounded).
   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_block(input string name, input logic [31:0] din, input logic dir,
                            input logic [31:0] exp, input int stall);
      int n;
      logic [31:0] held;
      @(negedge clk);
      chk({name, " in_ready idle"}, 32'(in_ready), 32'd1);
      drive_block(din, dir);
      out_ready = (stall == 0);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
      chk({name, " busy"}, 32'(busy), 32'd1);
      wait_out(n);
      chk({name, " latency"}, 32'(n), 32'd3);
      chk({name, " data"}, pack_out(), exp);
      held = pack_out();
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         @(negedge clk);
         chk({name, " held valid"}, 32'(out_valid), 32'd1);
         chk({name, " held data"}, pack_out(), held);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      chk({name, " blk_cnt"}, 32'(blk_cnt), 32'(model_cnt));
      chk({name, " valid low"}, 32'(out_valid), 32'd0);
      chk({name, " in_ready after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      int n;
      logic [31:0] din;
      logic        dir;

      vecs[0] = '{din: {8'd3, 8'd9, 8'd1, 8'd7},     dir: 1'b0, exp: {8'd9, 8'd7, 8'd3, 8'd1}};
      vecs[1] = '{din: {8'd3, 8'd9, 8'd1, 8'd7},     dir: 1'b1, exp: {8'd1, 8'd3, 8'd7, 8'd9}};
      vecs[2] = '{din: {8'd0, 8'd255, 8'd0, 8'd255}, dir: 1'b0, exp: {8'd255, 8'd255, 8'd0, 8'd0}};
      vecs[3] = '{din: {8'd5, 8'd5, 8'd5, 8'd5},     dir: 1'b1, exp: {8'd5, 8'd5, 8'd5, 8'd5}};

      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_dir = 1'b0;
      for (int i = 0; i < 4; i++) in_data[i] = '0;
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd0);
      chk("reset blk_cnt", 32'(blk_cnt), 32'd0);
      chk("reset out_data", pack_out(), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      in_valid = 1'b0;
      rst = 1'b1;

      for (int v = 0; v < 4; v++)
         run_block($sformatf("vec%0d", v), vecs[v].din, vecs[v].dir, vecs[v].exp, 0);

      // Backpressure in DONE with a pending block, then same-edge handoff.
      @(negedge clk);
      drive_block({8'd3, 8'd9, 8'd1, 8'd7}, 1'b0);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive_block({8'd10, 8'd20, 8'd30, 8'd40}, 1'b0);
      chk("bp busy in_ready", 32'(in_ready), 32'd0);
      wait_out(n);
      chk("bp latency", 32'(n), 32'd3);
      for (int s = 0; s < 5; s++) begin
         chk("bp valid", 32'(out_valid), 32'd1);
         chk("bp in_ready", 32'(in_ready), 32'd0);
         chk("bp data", pack_out(), {8'd9, 8'd7, 8'd3, 8'd1});
         chk("bp blk_cnt", 32'(blk_cnt), 32'(model_cnt));
         @(posedge clk);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("handoff in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      chk("handoff blk_cnt", 32'(blk_cnt), 32'(model_cnt));
      chk("handoff valid low", 32'(out_valid), 32'd0);
      chk("handoff busy", 32'(busy), 32'd1);
      wait_out(n);
      chk("handoff latency", 32'(n), 32'd3);
      chk("handoff data", pack_out(), {8'd40, 8'd30, 8'd20, 8'd10});
      @(posedge clk);
      @(negedge clk);
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      chk("handoff2 blk_cnt", 32'(blk_cnt), 32'(model_cnt));

      // Reset during STEP2.
      drive_block({8'd50, 8'd60, 8'd70, 8'd80}, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd0);
      chk("midrst blk_cnt", 32'(blk_cnt), 32'd0);
      chk("midrst out_data", pack_out(), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      model_cnt = 0;
      #1;
      chk("post rst in_ready", 32'(in_ready), 32'd1);

      // Random blocks against the reference model; 17 blocks wrap the 4-bit counter to 1.
      for (int b = 0; b < 17; b++) begin
         din = $urandom;
         if (b % 5 == 0) din[15:8] = din[31:24];
         dir = 1'($urandom);
         run_block($sformatf("rnd%0d", b), din, dir, ref_sort(din, dir), int'($urandom_range(0, 2)));
      end
      chk("wrap blk_cnt", 32'(blk_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
